// File: rtl/floppy_read_arbiter_pkg.sv
// Shared definitions for the floppy read arbiter: FSM state encoding,
// drive identifiers and the round-robin grant helper.
package floppy_read_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT
    } state_t;

    // Drive identifiers double as the grant value and the req/ack bit index.
    localparam logic DRV_INT = 1'b0;
    localparam logic DRV_EXT = 1'b1;

    // Pick the drive to serve from a non-zero request vector. A lone request
    // wins outright; on a tie the drive that was not served last goes next.
    function automatic logic pick_drive(input logic [1:0] req, input logic last_grant);
        if (req == 2'b11)
            return ~last_grant;
        else if (req[DRV_INT])
            return DRV_INT;
        else
            return DRV_EXT;
    endfunction

endpackage

// File: rtl/floppy_read_arbiter.sv
// Serialises byte reads from the internal and external floppy models onto a
// single memory read port. Adds a per-drive image base, returns data with a
// one-cycle per-drive ack, and forces completion with an all-ones byte if the
// memory port does not answer within TIMEOUT cycles.
module floppy_read_arbiter
    import floppy_read_arbiter_pkg::*;
#(
    parameter int                ADDR_W  = 22,
    parameter int                DATA_W  = 8,
    parameter logic [ADDR_W-1:0] BASE0   = 22'h000000,
    parameter logic [ADDR_W-1:0] BASE1   = 22'h0E0000,
    parameter int                TIMEOUT = 255
) (
    input  logic              clk8,
    input  logic              _reset,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              timeout,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    // Watchdog value seen on the last WAIT cycle before forced completion.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       gnt;
    logic       last_grant;
    logic [7:0] watchdog;
    logic       next_gnt;

    assign next_gnt = pick_drive(req, last_grant);

    // NOTE: busy decodes the state register directly, so it rises the cycle
    // after a grant and needs no extra flop of its own.
    assign busy = (state != S_IDLE);

    // Arbitration FSM with watchdog; every output except busy is registered.
    always_ff @(posedge clk8) begin
        if (!_reset) begin
            state      <= S_IDLE;
            gnt        <= DRV_INT;
            last_grant <= DRV_EXT;
            watchdog   <= '0;
            ack        <= '0;
            timeout    <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            rdata      <= '0;
        end else begin
            // NOTE: pulse outputs default low every cycle and are raised only
            // in the completing branch, which keeps them exactly one cycle wide.
            ack     <= '0;
            timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        gnt        <= next_gnt;
                        last_grant <= next_gnt;
                        // Carry out of the base addition is dropped by design.
                        mem_addr   <= (next_gnt == DRV_EXT) ? (BASE1 + addr1)
                                                            : (BASE0 + addr0);
                        state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    mem_req  <= 1'b1;
                    watchdog <= '0;
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (mem_ack) begin
                        rdata    <= mem_data;
                        mem_req  <= 1'b0;
                        ack[gnt] <= req[gnt];
                        state    <= S_IDLE;
                    end else if (watchdog == WD_LAST) begin
                        rdata    <= '1;
                        mem_req  <= 1'b0;
                        ack[gnt] <= req[gnt];
                        timeout  <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        watchdog <= watchdog + 8'd1;
                    end
                end

                default: begin
                    mem_req <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floppy_read_arbiter.sv
// Directed bench for floppy_read_arbiter. Two instances share all inputs:
// dut_a uses the default bases, dut_b moves BASE1 to 22'h3FFFF0 so the
// wrapped drive-1 address is observed on the same traffic. Both use TIMEOUT=16.
module tb_floppy_read_arbiter;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 8;

    logic              clk8 = 1'b0;
    logic              _reset;
    logic [1:0]        req;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;

    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic              timeout;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              busy;

    logic [1:0]        b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              b_timeout;
    logic              b_mem_req;
    logic [ADDR_W-1:0] b_mem_addr;
    logic              b_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk8 = ~clk8;

    floppy_read_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .BASE0(22'h000000), .BASE1(22'h0E0000), .TIMEOUT(16)
    ) dut_a (
        .clk8(clk8), ._reset(_reset), .req(req), .addr0(addr0), .addr1(addr1),
        .ack(ack), .rdata(rdata), .timeout(timeout), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data), .busy(busy)
    );

    floppy_read_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .BASE0(22'h000000), .BASE1(22'h3FFFF0), .TIMEOUT(16)
    ) dut_b (
        .clk8(clk8), ._reset(_reset), .req(req), .addr0(addr0), .addr1(addr1),
        .ack(b_ack), .rdata(b_rdata), .timeout(b_timeout), .mem_req(b_mem_req),
        .mem_addr(b_mem_addr), .mem_ack(mem_ack), .mem_data(mem_data), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk8);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        _reset = 1'b0;
        ticks(2);
        _reset = 1'b1;
    endtask

    // Bounded wait for mem_req; an expired budget shows up as a failed check.
    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(mem_req), 32'd1);
    endtask

    // Present a one-cycle memory completion.
    task automatic mem_done(input logic [DATA_W-1:0] data);
        mem_ack  = 1'b1;
        mem_data = data;
        tick();
        mem_ack  = 1'b0;
        mem_data = 8'h00;
    endtask

    initial begin
        logic [1:0]        exp_ack;
        logic [ADDR_W-1:0] exp_addr;
        logic [ADDR_W-1:0] exp_b_addr;

        _reset   = 1'b0;
        req      = 2'b00;
        addr0    = 22'h000010;
        addr1    = 22'h000020;
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        ticks(2);

        // Reset state
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        _reset = 1'b1;

        // 1: single read on drive 0, memory answers 4 cycles after mem_req
        req = 2'b01;
        tick();
        check("t1_busy_issue", 32'(busy), 32'd1);
        check("t1_no_req_yet", 32'(mem_req), 32'd0);
        tick();
        check("t1_mem_req_latency", 32'(mem_req), 32'd1);
        check("t1_mem_addr", 32'(mem_addr), 32'h000010);
        addr0 = 22'h000333;               // must not disturb in-flight access
        ticks(3);
        check("t1_mem_req_held", 32'(mem_req), 32'd1);
        check("t1_addr_stable", 32'(mem_addr), 32'h000010);
        check("t1_no_early_ack", 32'(ack), 32'd0);
        mem_done(8'hA5);
        req   = 2'b00;
        addr0 = 22'h000010;
        check("t1_ack", 32'(ack), 32'b01);
        check("t1_rdata", 32'(rdata), 32'hA5);
        check("t1_timeout_low", 32'(timeout), 32'd0);
        check("t1_mem_req_drop", 32'(mem_req), 32'd0);
        tick();
        check("t1_ack_one_cycle", 32'(ack), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2 + 3: tie held for six completions, grants alternate from drive 0
        do_reset();
        req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            exp_ack    = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr   = (i % 2 == 0) ? 22'h000010 : 22'h0E0020;
            exp_b_addr = 22'h000010;     // drive 1 wraps: 3FFFF0 + 20
            wait_mem_req($sformatf("t2_mem_req_%0d", i));
            check($sformatf("t2_mem_addr_%0d", i), 32'(mem_addr), 32'(exp_addr));
            check($sformatf("t3_wrap_addr_%0d", i), 32'(b_mem_addr), 32'(exp_b_addr));
            ticks(1);
            mem_done(8'h40 + 8'(i));
            check($sformatf("t2_ack_%0d", i), 32'(ack), 32'(exp_ack));
            check($sformatf("t2_rdata_%0d", i), 32'(rdata), 32'h40 + 32'(i));
        end
        req = 2'b00;
        ticks(3);
        check("t2_idle", 32'(busy), 32'd0);

        // 4: timeout after 16 WAIT cycles, late mem_ack ignored
        do_reset();
        req = 2'b01;
        ticks(2);
        check("t4_mem_req", 32'(mem_req), 32'd1);
        ticks(15);
        check("t4_still_waiting", 32'(mem_req), 32'd1);
        check("t4_no_ack_yet", 32'(ack), 32'd0);
        check("t4_no_timeout_yet", 32'(timeout), 32'd0);
        tick();
        req = 2'b00;
        check("t4_ack", 32'(ack), 32'b01);
        check("t4_timeout", 32'(timeout), 32'd1);
        check("t4_rdata_ff", 32'(rdata), 32'hFF);
        check("t4_mem_req_low", 32'(mem_req), 32'd0);
        mem_done(8'h77);
        check("t4_late_rdata", 32'(rdata), 32'hFF);
        check("t4_late_ack", 32'(ack), 32'd0);
        check("t4_timeout_pulse", 32'(timeout), 32'd0);
        check("t4_late_busy", 32'(busy), 32'd0);

        // 5: request withdrawn during WAIT
        do_reset();
        req = 2'b01;
        ticks(4);
        check("t5_in_wait", 32'(mem_req), 32'd1);
        req = 2'b00;
        mem_done(8'h3C);
        check("t5_no_ack", 32'(ack), 32'd0);
        check("t5_rdata", 32'(rdata), 32'h3C);
        check("t5_busy", 32'(busy), 32'd0);
        tick();
        check("t5_no_late_ack", 32'(ack), 32'd0);

        // 6: reset in the middle of WAIT, then tie goes to drive 0
        req = 2'b01;
        ticks(4);
        check("t6_in_wait", 32'(mem_req), 32'd1);
        _reset = 1'b0;
        tick();
        check("t6_mem_req", 32'(mem_req), 32'd0);
        check("t6_ack", 32'(ack), 32'd0);
        check("t6_rdata", 32'(rdata), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        _reset = 1'b1;
        req    = 2'b11;
        wait_mem_req("t6_mem_req_again");
        check("t6_tie_addr", 32'(mem_addr), 32'h000010);
        mem_done(8'h5A);
        req = 2'b00;
        check("t6_tie_ack", 32'(ack), 32'b01);
        check("t6_rdata_after", 32'(rdata), 32'h5A);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
